// File: rtl/emergency_request_arbiter.sv
// ============================================================================
// emergency_request_arbiter: synchronizes and debounces four siren-detector
// requests, then grants one direction round-robin through IDLE/ACTIVE/HOLD/
// COOLDOWN. Optional macro EMG_TIMEOUT_EN adds an ACTIVE time limit with fault.
// Revision: 1.0
// ============================================================================
`default_nettype none

module emergency_request_arbiter #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int HOLD_CYCLES      = 8,
    parameter int COOLDOWN_CYCLES  = 4,
    parameter int MAX_GRANT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_raw,
    output logic       emergency,
    output logic [1:0] emg_dir,
    output logic       fault
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACTIVE   = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] COOLDOWN = 2'd3;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255 ||
        MAX_GRANT_CYCLES < 1) begin : g_bad_params
        $error("emergency_request_arbiter: parameter out of range");
    end

    logic [3:0]        sync_meta;
    logic [3:0]        sync_req;
    logic [3:0]        deb;
    logic [3:0]        avail;
    logic [1:0]        state;
    logic [1:0]        last_grant;
    logic [1:0]        pick;
    logic              pick_valid;
    logic              timeout_hit;
    logic [HOLD_W-1:0] hold_cnt;
    logic [COOL_W-1:0] cool_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 4'b0000;
            sync_req  <= 4'b0000;
        end else begin
            sync_meta <= req_raw;
            sync_req  <= sync_meta;
        end
    end

    // Any cycle where the synchronized bit agrees with the level restarts the count.
    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [DB_W-1:0] cnt;
        logic            level;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync_req[i] == level) begin
                cnt <= '0;
            end else if (cnt >= DB_LAST) begin
                level <= sync_req[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[i] = level;
    end

    always_comb begin
        pick       = last_grant;
        pick_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_valid && avail[last_grant + 2'(k)]) begin
                pick       = last_grant + 2'(k);
                pick_valid = 1'b1;
            end
        end
    end

`ifdef EMG_TIMEOUT_EN
    localparam int ACT_W = $clog2(MAX_GRANT_CYCLES + 1);
    localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(MAX_GRANT_CYCLES - 1);

    logic [ACT_W-1:0] active_cnt;
    logic [3:0]       mask;
    logic [3:0]       mask_next;

    assign timeout_hit = (state == ACTIVE) && (active_cnt >= ACT_LAST);
    assign avail       = deb & ~mask;

    // A timed-out direction stays masked until its debounced request falls.
    always_comb begin
        mask_next = mask & deb;
        if (timeout_hit) begin
            mask_next = mask_next | (4'b0001 << emg_dir);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_cnt <= '0;
            mask       <= 4'b0000;
            fault      <= 1'b0;
        end else begin
            if (state == ACTIVE && !timeout_hit) begin
                if (active_cnt < ACT_LAST) begin
                    active_cnt <= active_cnt + 1'b1;
                end
            end else begin
                active_cnt <= '0;
            end
            mask  <= mask_next;
            fault <= |mask_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign avail       = deb;
    assign fault       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            emergency  <= 1'b0;
            emg_dir    <= 2'b00;
            last_grant <= 2'b11;
            hold_cnt   <= '0;
            cool_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= ACTIVE;
                        emergency  <= 1'b1;
                        emg_dir    <= pick;
                        last_grant <= pick;
                    end
                end
                ACTIVE: begin
                    if (timeout_hit) begin
                        state     <= COOLDOWN;
                        emergency <= 1'b0;
                        emg_dir   <= 2'b00;
                        cool_cnt  <= '0;
                    end else if (!deb[emg_dir]) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (deb[emg_dir]) begin
                        state    <= ACTIVE;
                        hold_cnt <= '0;
                    end else if (hold_cnt >= HOLD_LAST) begin
                        state     <= COOLDOWN;
                        emergency <= 1'b0;
                        emg_dir   <= 2'b00;
                        cool_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (cool_cnt >= COOL_LAST) begin
                        state <= IDLE;
                    end else begin
                        cool_cnt <= cool_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    emergency <= 1'b0;
                    emg_dir   <= 2'b00;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/emergency_request_arbiter.md
EMERGENCY_REQUEST_ARBITER -- requirements
Module: emergency_request_arbiter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles needed to change a debounced request (range 1..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: cycles emergency stays high after the granted request drops (range 1..255).
REQ-003 SHALL have parameter COOLDOWN_CYCLES, default 4: cycles emergency is forced low before a new grant (range 1..255).
REQ-004 SHALL have parameter MAX_GRANT_CYCLES, default 64: ACTIVE-state limit, used only with EMG_TIMEOUT_EN.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_raw  input  4  asynchronous siren-detector requests; bit0 N, bit1 E, bit2 S, bit3 W.
REQ-008 SHALL have port emergency  output  1  registered emergency request to the traffic light controller.
REQ-009 SHALL have port emg_dir  output  2  registered granted direction, 00 N, 01 E, 10 S, 11 W.
REQ-010 SHALL have port fault  output  1  registered stuck-request flag.

Function
REQ-011 SHALL pass each req_raw bit through a 2-flop synchronizer.
REQ-012 SHALL debounce each bit independently: the debounced level changes only after the synchronized bit differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break restarts that bit's counter.
REQ-013 SHALL implement states IDLE, ACTIVE, HOLD, COOLDOWN.
REQ-014 IDLE: emergency=0, emg_dir=00; on any debounced request go to ACTIVE and register the grant the same edge.
REQ-015 SHALL arbitrate round-robin: search starts at the direction after the last granted one, wrapping W->N; last-granted resets to W so N wins first.
REQ-016 ACTIVE: emergency=1, emg_dir fixed to the grant; other requests ignored; granted debounced request low -> HOLD.
REQ-017 HOLD: emergency=1, emg_dir unchanged; granted request re-asserted -> ACTIVE with hold counter cleared; after exactly HOLD_CYCLES cycles in HOLD -> COOLDOWN.
REQ-018 COOLDOWN: emergency=0, emg_dir=00, requests ignored for exactly COOLDOWN_CYCLES cycles, then IDLE.
REQ-019 emg_dir SHALL never change while emergency=1.
REQ-020 Latency from req_raw rising (stable) to emergency rising SHALL be 2 + DEBOUNCE_CYCLES + 1 edges from IDLE.
REQ-021 Counters SHALL be sized with $clog2 of their parameter + 1 and SHALL saturate, never wrap.

Reset
REQ-022 reset low SHALL asynchronously clear: state=IDLE, emergency=0, emg_dir=00, fault=0, synchronizers/debounced levels/counters=0, last-granted=W.
REQ-023 reset asserted mid-grant SHALL drop emergency immediately without HOLD or COOLDOWN; release is synchronous to clk.

Configuration
REQ-024 Macro EMG_TIMEOUT_EN defined: after MAX_GRANT_CYCLES consecutive cycles in ACTIVE, go to COOLDOWN, set fault=1, mask that direction from arbitration until its debounced request falls, then clear fault.
REQ-025 EMG_TIMEOUT_EN undefined: ACTIVE has no time limit, no timeout counter is built, fault is tied 0.

Verification
REQ-026 reset low with req_raw=1111 -> emergency=0, emg_dir=00, fault=0 throughout; after release N granted at edge 7.
REQ-027 Defaults, req_raw=0010 held 30 cycles -> emergency=1, emg_dir=01 at edge 7 after rise, constant while held.
REQ-028 Then req_raw=0000 -> emergency stays 1 for debounce+sync latency plus 8 HOLD cycles, then 0 for 4 COOLDOWN cycles; req_raw=0001 raised during COOLDOWN granted only after IDLE reached.
REQ-029 req_raw=1111 after reset, N dropped once granted -> N granted (00), then after hold/cooldown E granted (01), not N or W.
REQ-030 3-cycle glitch on req_raw[2] -> emergency never asserts, debounced level unchanged.
REQ-031 EMG_TIMEOUT_EN, req_raw=0100 held 150 cycles -> emergency drops after 64 ACTIVE cycles, fault=1, no regrant of S; fault clears after release debounces.
